mem_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the native memory bus (valid/ready/addr/wdata/wstrb/rdata) in front of the BRAM controller.
- Master 0 is the CPU core; master 1 is the UART program loader / debug port.
- Each transaction is granted to one master and held until the slave returns ready or a timeout fires.
- A timeout error response prevents a stuck slave from hanging the CPU.

---
 rtl/mem_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave arbiter for the native memory bus in front of the BRAM controller.
// Master 0 is the CPU, master 1 the UART loader / debug port. A granted transaction is held
// until the slave returns ready or the wait counter expires, in which case the master gets an
// error response and the sticky timeout flag is set.
// Define MEM_BUS_ARBITER_RR_EN for round-robin arbitration; default is fixed priority (m1 wins).
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 31,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    output logic        timeout_err
);

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1, StRespErr} state_e;

    // Counter value in the last grant cycle before an error response is forced.
    localparam logic [7:0] CntLimit = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        sel_q, sel_d;     // master owning the current transaction
    logic        err_q, err_d;
    logic        pick;             // master chosen when leaving idle
    logic        in_grant;
    logic        done;             // transaction finished this cycle (completion or error)

    assign in_grant = (state_q == StGrant0) || (state_q == StGrant1);
    assign done     = (in_grant && s_ready) || (state_q == StRespErr);

`ifdef MEM_BUS_ARBITER_RR_EN
    logic last_q, last_d;

    // Round-robin choice: on contention the master not served last wins.
    always_comb begin
        if (m0_valid && m1_valid) begin
            pick = ~last_q;
        end else begin
            pick = m1_valid;
        end
    end

    // Last-served pointer follows every completion or error response.
    always_comb begin
        last_d = last_q;
        if (done) begin
            last_d = sel_q;
        end
    end

    // Pointer register; reset value says master 0 was served last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: the loader always beats the CPU.
    always_comb begin
        pick = m1_valid;
    end
`endif

    // Next-state logic: arbitration, request latching and the timeout counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        sel_d   = sel_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                if (m0_valid || m1_valid) begin
                    sel_d   = pick;
                    addr_d  = pick ? m1_addr  : m0_addr;
                    wdata_d = pick ? m1_wdata : m0_wdata;
                    wstrb_d = pick ? m1_wstrb : m0_wstrb;
                    state_d = pick ? StGrant1 : StGrant0;
                end
            end
            StGrant0, StGrant1: begin
                // s_ready takes precedence over an expiring counter.
                if (s_ready) begin
                    state_d = StIdle;
                end else if (cnt_q == CntLimit) begin
                    state_d = StRespErr;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StRespErr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    // Outputs come from registered state only; ready additionally passes s_ready through.
    always_comb begin
        s_valid     = in_grant;
        s_addr      = addr_q;
        s_wdata     = wdata_q;
        s_wstrb     = wstrb_q;
        m0_ready    = ((state_q == StGrant0) && s_ready) || ((state_q == StRespErr) && !sel_q);
        m1_ready    = ((state_q == StGrant1) && s_ready) || ((state_q == StRespErr) && sel_q);
        m0_rdata    = ((state_q == StRespErr) && !sel_q) ? ERR_RDATA : s_rdata;
        m1_rdata    = ((state_q == StRespErr) && sel_q) ? ERR_RDATA : s_rdata;
        timeout_err = err_q;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter (default TIMEOUT_CYCLES=31, ERR_RDATA=DEADBEEF).
// Inputs are driven 1 ns after the rising edge, outputs sampled 1 ns after that.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_valid, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_bus_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .m0_valid    (m0_valid),
        .m0_ready    (m0_ready),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_wstrb    (m0_wstrb),
        .m0_rdata    (m0_rdata),
        .m1_valid    (m1_valid),
        .m1_ready    (m1_ready),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_wstrb    (m1_wstrb),
        .m1_rdata    (m1_rdata),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_rdata     (s_rdata),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic        exp_m0_first;
    logic [31:0] exp_addr2, exp_addr3;
    int          n_cyc;

    initial begin
        reset    = 1'b1;
        m0_valid = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'd0;
        m1_valid = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wstrb = 4'd0;
        s_ready  = 1'b0; s_rdata = 32'd0;

        // Reset state
        #2;
        check_eq("rst_s_valid", 32'(s_valid), 32'd0);
        check_eq("rst_m0_ready", 32'(m0_ready), 32'd0);
        check_eq("rst_m1_ready", 32'(m1_ready), 32'd0);
        check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
        check_eq("rst_s_addr", s_addr, 32'd0);
        step(); step();
        reset = 1'b0;

        // s_ready in idle is ignored
        s_ready = 1'b1;
        #1;
        check_eq("idle_sready_m0", 32'(m0_ready), 32'd0);
        check_eq("idle_sready_m1", 32'(m1_ready), 32'd0);
        step();
        s_ready = 1'b0;

        // Single CPU read, slave ready 4 cycles after s_valid rises
        m0_valid = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'b0000;
        #1;
        check_eq("rd_s_valid_lat0", 32'(s_valid), 32'd0);
        step(); #1;
        check_eq("rd_s_valid", 32'(s_valid), 32'd1);
        check_eq("rd_s_addr", s_addr, 32'h10);
        check_eq("rd_s_wstrb", 32'(s_wstrb), 32'd0);
        step(); step(); step();
        #1;
        check_eq("rd_wait_m0_ready", 32'(m0_ready), 32'd0);
        step();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        #1;
        check_eq("rd_m0_ready", 32'(m0_ready), 32'd1);
        check_eq("rd_m0_rdata", m0_rdata, 32'h1234_5678);
        check_eq("rd_m1_ready", 32'(m1_ready), 32'd0);
        step();
        s_ready = 1'b0; m0_valid = 1'b0;
        #1;
        check_eq("rd_idle_s_valid", 32'(s_valid), 32'd0);
        check_eq("rd_idle_m0_ready", 32'(m0_ready), 32'd0);

        // Contention: m1 writes 0x20, m0 reads 0x24. After its completion m1 immediately
        // requests again (write 0x28), creating a second contention.
`ifdef MEM_BUS_ARBITER_RR_EN
        exp_m0_first = 1'b1; exp_addr2 = 32'h24; exp_addr3 = 32'h28;
`else
        exp_m0_first = 1'b0; exp_addr2 = 32'h28; exp_addr3 = 32'h24;
`endif
        step();
        m1_valid = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'b1111;
        m0_valid = 1'b1; m0_addr = 32'h24; m0_wstrb = 4'b0000;
        step(); #1;
        check_eq("c1_s_addr", s_addr, 32'h20);
        check_eq("c1_s_wdata", s_wdata, 32'hA5A5_A5A5);
        check_eq("c1_s_wstrb", 32'(s_wstrb), 32'hF);
        s_ready = 1'b1; s_rdata = 32'h0;
        #1;
        check_eq("c1_m1_ready", 32'(m1_ready), 32'd1);
        check_eq("c1_m0_ready", 32'(m0_ready), 32'd0);
        step();
        s_ready = 1'b0;
        m1_addr = 32'h28; m1_wdata = 32'h0F0F_0F0F;
        #1;
        check_eq("c1_idle_gap", 32'(s_valid), 32'd0);
        step(); #1;
        check_eq("c2_s_addr", s_addr, exp_addr2);
        s_ready = 1'b1; s_rdata = 32'hCAFE_0001;
        #1;
        check_eq("c2_m0_ready", 32'(m0_ready), 32'(exp_m0_first));
        check_eq("c2_m1_ready", 32'(m1_ready), 32'(!exp_m0_first));
        check_eq("c2_m1_rdata", m1_rdata, 32'hCAFE_0001);
        step();
        s_ready = 1'b0;
        if (exp_m0_first) m0_valid = 1'b0;
        else m1_valid = 1'b0;
        #1;
        check_eq("c2_idle_gap", 32'(s_valid), 32'd0);
        step(); #1;
        check_eq("c3_s_addr", s_addr, exp_addr3);
        s_ready = 1'b1;
        #1;
        check_eq("c3_m0_ready", 32'(m0_ready), 32'(!exp_m0_first));
        check_eq("c3_m1_ready", 32'(m1_ready), 32'(exp_m0_first));
        step();
        s_ready = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;

        // Timeout: slave never ready
        step();
        m0_valid = 1'b1; m0_addr = 32'h30; m0_wstrb = 4'b0000;
        s_rdata  = 32'h1111_2222;
        step(); #1;
        n_cyc = 0;
        while (s_valid && n_cyc < 100) begin
            n_cyc++;
            step(); #1;
        end
        check_eq("to_s_valid_cycles", 32'(n_cyc), 32'd31);
        check_eq("to_s_valid_low", 32'(s_valid), 32'd0);
        check_eq("to_m0_ready", 32'(m0_ready), 32'd1);
        check_eq("to_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        check_eq("to_m1_ready", 32'(m1_ready), 32'd0);
        check_eq("to_m1_rdata", m1_rdata, 32'h1111_2222);
        check_eq("to_err_set", 32'(timeout_err), 32'd1);
        m0_valid = 1'b0;
        step(); #1;
        check_eq("to_m0_ready_pulse", 32'(m0_ready), 32'd0);
        step(); step(); #1;
        check_eq("to_err_sticky", 32'(timeout_err), 32'd1);

        // Reset clears sticky error
        reset = 1'b1;
        #1;
        check_eq("rst2_err_clr", 32'(timeout_err), 32'd0);
        step();
        reset = 1'b0;

        // s_ready in the last allowed cycle wins over the timeout
        m0_valid = 1'b1; m0_addr = 32'h34;
        step();
        for (int i = 0; i < 30; i++) step();
        s_ready = 1'b1; s_rdata = 32'h5555_AAAA;
        #1;
        check_eq("lim_s_valid", 32'(s_valid), 32'd1);
        check_eq("lim_m0_ready", 32'(m0_ready), 32'd1);
        check_eq("lim_m0_rdata", m0_rdata, 32'h5555_AAAA);
        step();
        s_ready = 1'b0; m0_valid = 1'b0;
        #1;
        check_eq("lim_s_valid_low", 32'(s_valid), 32'd0);
        check_eq("lim_no_err_resp", 32'(m0_ready), 32'd0);
        check_eq("lim_err_clear", 32'(timeout_err), 32'd0);

        // Asynchronous reset two cycles into a grant
        step();
        m0_valid = 1'b1; m0_addr = 32'h38;
        step(); step(); step();
        s_ready = 1'b1;
        #1;
        check_eq("ar_pre_m0_ready", 32'(m0_ready), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("ar_s_valid", 32'(s_valid), 32'd0);
        check_eq("ar_m0_ready", 32'(m0_ready), 32'd0);
        step();
        reset = 1'b0; s_ready = 1'b0; m0_addr = 32'h3C;
        step(); #1;
        check_eq("ar_fresh_s_addr", s_addr, 32'h3C);
        s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
        #1;
        check_eq("ar_fresh_m0_ready", 32'(m0_ready), 32'd1);
        check_eq("ar_fresh_m0_rdata", m0_rdata, 32'h0BAD_F00D);
        step();
        s_ready = 1'b0; m0_valid = 1'b0;

        // Address changes mid-grant; latched address must hold
        step();
        m0_valid = 1'b1; m0_addr = 32'h10;
        step();
        m0_addr = 32'h40;
        step(); #1;
        check_eq("hold_s_addr_mid", s_addr, 32'h10);
        step();
        s_ready = 1'b1; s_rdata = 32'h7777_0000;
        #1;
        check_eq("hold_s_addr_end", s_addr, 32'h10);
        check_eq("hold_m0_ready", 32'(m0_ready), 32'd1);
        step();
        s_ready = 1'b0; m0_valid = 1'b0;
        #1;
        check_eq("hold_idle", 32'(s_valid), 32'd0);
        check_eq("end_no_err", 32'(timeout_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
